demux4_stream: RTL and testbench

DEMUX4_STREAM -- requirements
Module: demux4_stream

---
 rtl/demux4_stream_pkg.sv | 33 +++
 rtl/demux4_stream_slot.sv | 61 ++++++
 rtl/demux4_stream.sv | 78 +++++++
 tb/tb_demux4_stream.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// slot state encoding, counter widths and a saturating drop-count adder.
package mopshub_demux_pkg;

  localparam int NUM_CH  = 4;
  localparam int STALL_W = 8;
  localparam int DROP_W  = 8;

  // A channel slot either holds an undelivered word or it does not.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Number of channels that discarded a word on the same edge.
  function automatic logic [2:0] count_fires(input logic [NUM_CH-1:0] fires);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + {2'b00, fires[i]};
    end
    return n;
  endfunction

  // Add several discards at once, sticking at the all-ones value.
  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                     input logic [2:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-2){1'b0}}, inc};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/demux4_stream_slot.sv
// One output channel of the demultiplexer: a single-word holding slot with a
// stall counter that discards the word after TIMEOUT consecutive stalled
// cycles and flags the discard with a one-cycle pulse.
//
// Handshake: a word moves on a rising edge only when its valid and the
// matching ready are both high; valid never depends on ready, and ready is
// ignored while valid is low.
module demux_slot
  import mopshub_demux_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         ready,
  output slot_state_t  state,
  output logic [N-1:0] data,
  output logic         timeout_fire,
  output logic         timeout_err
);

  // Stall count at which the next stalled edge is the TIMEOUT-th one.
  localparam logic [STALL_W-1:0] LAST_STALL = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;

  // Discard only when the word is still stuck on this edge: a delivery or a
  // fresh load on the same edge wins over the timeout.
  always_comb begin
    timeout_fire = (state == SLOT_FULL) && !ready && !load && (stall_cnt == LAST_STALL);
  end

  // Slot state, held word, stall counter and registered discard pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SLOT_EMPTY;
      data        <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_fire;
      if (load) begin
        // Covers both the empty-slot load and the deliver-and-reload case.
        state     <= SLOT_FULL;
        data      <= load_data;
        stall_cnt <= '0;
      end else if (state == SLOT_FULL) begin
        if (ready || timeout_fire) begin
          state     <= SLOT_EMPTY;
          stall_cnt <= '0;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 stream router: each accepted word goes to the channel named by
// sel_in at acceptance. Each channel holds one word until its consumer takes
// it or it times out; discards are counted in a saturating drop counter.
//
// Handshake: input accepted on a rising edge when valid_in & ready_out;
// channel k delivers when valid_out[k] & ready_in[k]. ready_out looks only
// at the selected channel, so a stalled channel never blocks the others.
module demux4_stream
  import mopshub_demux_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       data_in,
  input  logic [1:0]         sel_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [N-1:0]       data_out0,
  output logic [N-1:0]       data_out1,
  output logic [N-1:0]       data_out2,
  output logic [N-1:0]       data_out3,
  output logic [NUM_CH-1:0]  valid_out,
  input  logic [NUM_CH-1:0]  ready_in,
  output logic [NUM_CH-1:0]  timeout_err,
  output logic [DROP_W-1:0]  drop_cnt
);

  slot_state_t       slot_state [NUM_CH];
  logic [N-1:0]      slot_data  [NUM_CH];
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] fire;
  logic              accept;

  // Ready for the selected channel and one-hot load decode.
  always_comb begin
    ready_out = !valid_out[sel_in] || ready_in[sel_in];
    accept    = valid_in && ready_out;
    load      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept && (sel_in == 2'(k));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .N       (N),
      .TIMEOUT (TIMEOUT)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .load         (load[k]),
      .load_data    (data_in),
      .ready        (ready_in[k]),
      .state        (slot_state[k]),
      .data         (slot_data[k]),
      .timeout_fire (fire[k]),
      .timeout_err  (timeout_err[k])
    );
    assign valid_out[k] = (slot_state[k] == SLOT_FULL);
  end

  assign data_out0 = slot_data[0];
  assign data_out1 = slot_data[1];
  assign data_out2 = slot_data[2];
  assign data_out3 = slot_data[3];

  // Saturating count of discarded words, all channels summed per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (|fire) begin
      drop_cnt <= sat_add_drop(drop_cnt, count_fires(fire));
    end
  end

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream with TIMEOUT=4. A behavioural model tracks, per
// channel, whether a word is held, its value and how many consecutive cycles
// it has been stuck, plus the total of discarded words.
module tb_demux4_stream;

  localparam int N  = 16;
  localparam int TO = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] data_in;
  logic [1:0]   sel_in;
  logic         valid_in;
  logic         ready_out;
  logic [N-1:0] data_out0, data_out1, data_out2, data_out3;
  logic [3:0]   valid_out;
  logic [3:0]   ready_in;
  logic [3:0]   timeout_err;
  logic [7:0]   drop_cnt;
  logic [N-1:0] dout [4];

  int errors = 0;
  int checks = 0;

  // model state
  bit           m_full  [4];
  logic [N-1:0] m_data  [4];
  int           m_stall [4];
  logic [3:0]   m_err;
  int           m_drop;

  demux4_stream #(.N(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .sel_in      (sel_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out0   (data_out0),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .data_out3   (data_out3),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt)
  );

  assign dout[0] = data_out0;
  assign dout[1] = data_out1;
  assign dout[2] = data_out2;
  assign dout[3] = data_out3;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k]  = 0;
      m_data[k]  = '0;
      m_stall[k] = 0;
    end
    m_err  = '0;
    m_drop = 0;
  endtask

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic m_ready(input logic [1:0] s, input logic [3:0] r);
    return !m_full[s] || r[s];
  endfunction

  // Drive inputs shortly after the falling edge.
  task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] d,
                       input logic [3:0] r);
    valid_in = v;
    sel_in   = s;
    data_in  = d;
    ready_in = r;
    #1;
  endtask

  // One rising edge; model advances on it, outputs sampled at the next fall.
  task automatic tick();
    logic         acc;
    logic [1:0]   s;
    logic [N-1:0] d;
    logic [3:0]   r;
    logic         in_rst;
    s      = sel_in;
    d      = data_in;
    r      = ready_in;
    in_rst = rst;
    acc    = valid_in && m_ready(s, r);
    @(posedge clk);
    if (in_rst) begin
      model_reset();
    end else begin
      m_err = '0;
      for (int k = 0; k < 4; k++) begin
        if (acc && s == 2'(k)) begin
          m_full[k]  = 1;
          m_data[k]  = d;
          m_stall[k] = 0;
        end else if (m_full[k] && r[k]) begin
          m_full[k]  = 0;
          m_stall[k] = 0;
        end else if (m_full[k]) begin
          m_stall[k] = m_stall[k] + 1;
          if (m_stall[k] == TO) begin
            m_full[k]  = 0;
            m_stall[k] = 0;
            m_err[k]   = 1'b1;
            m_drop     = (m_drop < 255) ? m_drop + 1 : 255;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (valid_out !== 4'h0) begin
      errors++; $display("FAIL reset_valid: got %h want 0", valid_out);
    end
    checks++;
    if (drop_cnt !== 8'h00 || timeout_err !== 4'h0) begin
      errors++; $display("FAIL reset_cnt: drop=%0d err=%h want 0/0", drop_cnt, timeout_err);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout[k] !== '0) begin
        errors++; $display("FAIL reset_data%0d: got %h want 0", k, dout[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready_out);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] w;
    for (int k = 0; k < 4; k++) begin
      w = 16'h1111 * 16'(k + 1);
      drive(1'b1, 2'(k), w, 4'hF);
      checks++;
      if (ready_out !== 1'b1 || valid_out[k] !== 1'b0) begin
        errors++; $display("FAIL basic_pre%0d: ready=%b valid=%b want 1/0", k, ready_out, valid_out[k]);
      end
      tick();
      checks++;
      if (valid_out !== (4'b1 << k) || dout[k] !== w) begin
        errors++; $display("FAIL basic_out%0d: valid=%h data=%h want %h/%h", k, valid_out, dout[k], 4'b1 << k, w);
      end
      checks++;
      if (timeout_err !== 4'h0 || drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL basic_err%0d: err=%h drop=%0d want 0/%0d", k, timeout_err, drop_cnt, m_drop);
      end
    end
    drive(1'b0, 2'd0, '0, 4'hF);
    tick();
    checks++;
    if (valid_out !== 4'h0) begin
      errors++; $display("FAIL basic_drain: valid=%h want 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd2, 16'hA5A5, 4'h0);
    tick();
    drive(1'b1, 2'd2, 16'h5A5A, 4'h0);
    checks++;
    if (ready_out !== 1'b0) begin
      errors++; $display("FAIL b2b_stall: ready=%b want 0", ready_out);
    end
    tick();
    checks++;
    if (valid_out[2] !== 1'b1 || data_out2 !== 16'hA5A5) begin
      errors++; $display("FAIL b2b_hold: valid=%b data=%h want 1/a5a5", valid_out[2], data_out2);
    end
    drive(1'b1, 2'd2, 16'h5A5A, 4'h4);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL b2b_drain_ready: ready=%b want 1", ready_out);
    end
    tick();
    checks++;
    if (valid_out[2] !== 1'b1 || data_out2 !== 16'h5A5A) begin
      errors++; $display("FAIL b2b_second: valid=%b data=%h want 1/5a5a", valid_out[2], data_out2);
    end
    drive(1'b0, 2'd0, '0, 4'h4);
    tick();
    checks++;
    if (valid_out !== 4'h0 || data_out2 !== 16'h5A5A) begin
      errors++; $display("FAIL b2b_empty: valid=%h data=%h want 0/5a5a", valid_out, data_out2);
    end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = m_drop;
    drive(1'b1, 2'd1, 16'hBEEF, 4'h0);
    tick();
    drive(1'b0, 2'd0, '0, 4'h0);
    for (int i = 1; i < TO; i++) begin
      tick();
      checks++;
      if (valid_out[1] !== 1'b1 || timeout_err !== 4'h0) begin
        errors++; $display("FAIL timeout_hold%0d: valid=%b err=%h want 1/0", i, valid_out[1], timeout_err);
      end
    end
    tick();
    checks++;
    if (valid_out[1] !== 1'b0 || timeout_err !== 4'b0010 || drop_cnt !== 8'(d0 + 1)) begin
      errors++; $display("FAIL timeout_fire: valid=%b err=%h drop=%0d want 0/2/%0d", valid_out[1], timeout_err, drop_cnt, d0 + 1);
    end
    tick();
    checks++;
    if (timeout_err !== 4'h0 || drop_cnt !== 8'(m_drop) || data_out1 !== 16'hBEEF) begin
      errors++; $display("FAIL timeout_after: err=%h drop=%0d data=%h want 0/%0d/beef", timeout_err, drop_cnt, data_out1, m_drop);
    end
  endtask

  task automatic test_timeout_rescue();
    int d0;
    d0 = m_drop;
    drive(1'b1, 2'd3, 16'hCAFE, 4'h0);
    tick();
    drive(1'b0, 2'd0, '0, 4'h0);
    for (int i = 1; i < TO; i++) tick();
    drive(1'b0, 2'd0, '0, 4'h8);
    tick();
    checks++;
    if (valid_out[3] !== 1'b0 || timeout_err !== 4'h0 || drop_cnt !== 8'(d0)) begin
      errors++; $display("FAIL rescue: valid=%b err=%h drop=%0d want 0/0/%0d", valid_out[3], timeout_err, drop_cnt, d0);
    end
    drive(1'b0, 2'd0, '0, 4'h0);
    tick();
    checks++;
    if (timeout_err !== 4'h0 || drop_cnt !== 8'(d0)) begin
      errors++; $display("FAIL rescue_after: err=%h drop=%0d want 0/%0d", timeout_err, drop_cnt, d0);
    end
  endtask

  task automatic test_isolation();
    logic [N-1:0] w;
    drive(1'b1, 2'd0, 16'h0F0F, 4'h0);
    tick();
    for (int k = 1; k < 4; k++) begin
      w = N'($urandom);
      drive(1'b1, 2'(k), w, 4'hE);
      checks++;
      if (ready_out !== 1'b1) begin
        errors++; $display("FAIL iso_ready%0d: got %b want 1", k, ready_out);
      end
      tick();
      checks++;
      if (valid_out[k] !== 1'b1 || dout[k] !== w || valid_out[0] !== 1'b1 || data_out0 !== 16'h0F0F) begin
        errors++; $display("FAIL iso_out%0d: valid=%h data=%h ch0=%h want ch%0d=%h ch0=0f0f", k, valid_out, dout[k], data_out0, k, w);
      end
    end
    drive(1'b0, 2'd0, '0, 4'hF);
    tick();
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 9) < 3);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), N'($urandom), r);
      checks++;
      if (ready_out !== m_ready(sel_in, ready_in)) begin
        errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, ready_out, m_ready(sel_in, ready_in));
      end
      tick();
      checks++;
      if (valid_out !== m_valid() || timeout_err !== m_err || drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL rand_state c%0d: valid=%h err=%h drop=%0d want %h/%h/%0d", c, valid_out, timeout_err, drop_cnt, m_valid(), m_err, m_drop);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dout[k] !== m_data[k]) begin
          errors++; $display("FAIL rand_data%0d c%0d: got %h want %h", k, c, dout[k], m_data[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int cyc;
    int pulses;
    cyc = 0;
    while (m_drop < 255 && cyc < 4000) begin
      drive(1'b1, 2'(cyc % 4), N'($urandom), 4'h0);
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 4000) begin
      errors++; $display("FAIL sat_budget: model drop=%0d after %0d cycles", m_drop, cyc);
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_reach: drop=%0d want 255", drop_cnt);
    end
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, 2'(c % 4), N'($urandom), 4'h0);
      tick();
      if (timeout_err != 4'h0) pulses++;
      checks++;
      if (drop_cnt !== 8'd255 || timeout_err !== m_err) begin
        errors++; $display("FAIL sat_hold c%0d: drop=%0d err=%h want 255/%h", c, drop_cnt, timeout_err, m_err);
      end
    end
    checks++;
    if (pulses == 0) begin
      errors++; $display("FAIL sat_pulses: got %0d discards while saturated want >0", pulses);
    end
  endtask

  task automatic test_reset_midstall();
    drive(1'b0, 2'd0, '0, 4'hF);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'(k), N'($urandom), 4'h0);
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'h0);
    tick();
    checks++;
    if (valid_out !== 4'b0111 || drop_cnt !== 8'd255) begin
      errors++; $display("FAIL rstmid_pre: valid=%h drop=%0d want 7/255", valid_out, drop_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 4'h0 || drop_cnt !== 8'h00 || timeout_err !== 4'h0) begin
      errors++; $display("FAIL rstmid_async: valid=%h drop=%0d err=%h want 0/0/0", valid_out, drop_cnt, timeout_err);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout[k] !== '0) begin
        errors++; $display("FAIL rstmid_data%0d: got %h want 0", k, dout[k]);
      end
    end
    @(negedge clk);
    drive(1'b1, 2'd1, 16'h1234, 4'h0);
    tick();
    checks++;
    if (valid_out !== 4'h0 || timeout_err !== 4'h0 || drop_cnt !== 8'h00) begin
      errors++; $display("FAIL rstmid_held: valid=%h err=%h drop=%0d want 0/0/0", valid_out, timeout_err, drop_cnt);
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, '0, 4'h0);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: got %b want 1", ready_out);
    end
    tick();
    checks++;
    if (timeout_err !== 4'h0 || drop_cnt !== 8'h00 || valid_out !== 4'h0) begin
      errors++; $display("FAIL rstmid_after: err=%h drop=%0d valid=%h want 0/0/0", timeout_err, drop_cnt, valid_out);
    end
  endtask

  initial begin
    rst      = 1'b1;
    data_in  = '0;
    sel_in   = '0;
    valid_in = 1'b0;
    ready_in = '0;
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_timeout_rescue();
    test_isolation();
    test_random();
    test_saturation();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
